// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified memory port arbiter: FSM encoding,
// grant identifiers and access counter width.
package mem_arb_pkg;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] CORE_ACC = 2'd1;
  localparam logic [1:0] LDR_ACC  = 2'd2;

  localparam logic GNT_CORE = 1'b0;
  localparam logic GNT_LDR  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// Round-robin pick between core and loader; with MEM_ARB_LDR_LOCK_EN the
// lock input masks the core so only the loader can be granted.
module mem_arb_rr_pick
  import mem_arb_pkg::*;
(
  input  logic core_elig,
  input  logic ldr_elig,
  input  logic last_grant,
`ifdef MEM_ARB_LDR_LOCK_EN
  input  logic lock,
`endif
  output logic grant_valid,
  output logic grant_id
);

  logic w_core_ok;

`ifdef MEM_ARB_LDR_LOCK_EN
  assign w_core_ok = core_elig & ~lock;
`else
  assign w_core_ok = core_elig;
`endif

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    grant_valid = w_core_ok | ldr_elig;
    grant_id    = GNT_CORE;
    if (w_core_ok && ldr_elig) begin
      grant_id = (last_grant == GNT_CORE) ? GNT_LDR : GNT_CORE;
    end else if (ldr_elig) begin
      grant_id = GNT_LDR;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between the core datapath and the
// loader/debug port. Optional loader lock: define MEM_ARB_LDR_LOCK_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_rd,
  input  logic              core_wr,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_ready,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_ready,
`ifdef MEM_ARB_LDR_LOCK_EN
  input  logic              ldr_lock,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(MEM_LAT - 1);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_last_grant;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_core_rdata;
  logic [DATA_W-1:0] r_ldr_rdata;
  logic              r_core_ready;
  logic              r_ldr_ready;

  logic w_core_elig;
  logic w_ldr_elig;
  logic w_grant_valid;
  logic w_grant_id;

  // A requester sitting in its own ready cycle is not eligible again yet.
  assign w_core_elig = (core_rd | core_wr) & ~r_core_ready;
  assign w_ldr_elig  = ldr_req & ~r_ldr_ready;

  mem_arb_rr_pick u_pick (
    .core_elig   (w_core_elig),
    .ldr_elig    (w_ldr_elig),
    .last_grant  (r_last_grant),
`ifdef MEM_ARB_LDR_LOCK_EN
    .lock        (ldr_lock),
`endif
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_last_grant <= GNT_LDR;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_rdata <= '0;
      r_ldr_rdata  <= '0;
      r_core_ready <= 1'b0;
      r_ldr_ready  <= 1'b0;
    end else begin
      r_core_ready <= 1'b0;
      r_ldr_ready  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant_valid) begin
            r_mem_en     <= 1'b1;
            r_cnt        <= LAT_M1;
            r_last_grant <= w_grant_id;
            if (w_grant_id == GNT_CORE) begin
              r_mem_addr  <= core_addr;
              r_mem_wdata <= core_wdata;
              r_mem_we    <= core_wr;
              r_state     <= CORE_ACC;
            end else begin
              r_mem_addr  <= ldr_addr;
              r_mem_wdata <= ldr_wdata;
              r_mem_we    <= ldr_we;
              r_state     <= LDR_ACC;
            end
          end
        end
        CORE_ACC, LDR_ACC: begin
          // Read data is only valid in the final strobe cycle.
          if (r_cnt == '0) begin
            if (!r_mem_we) begin
              if (r_state == CORE_ACC) r_core_rdata <= mem_rdata;
              else                     r_ldr_rdata  <= mem_rdata;
            end
            if (r_state == CORE_ACC) r_core_ready <= 1'b1;
            else                     r_ldr_ready  <= 1'b1;
            r_mem_en <= 1'b0;
            r_mem_we <= 1'b0;
            r_state  <= IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign core_rdata = r_core_rdata;
  assign core_ready = r_core_ready;
  assign ldr_rdata  = r_ldr_rdata;
  assign ldr_ready  = r_ldr_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: cycle vector table for the directed cases, then
// randomized traffic against a timestamp-based reference model.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_rd = 1'b0, core_wr = 1'b0;
  logic [31:0] core_addr = '0, core_wdata = '0;
  logic [31:0] core_rdata;
  logic        core_ready;
  logic        ldr_req = 1'b0, ldr_we = 1'b0;
  logic [31:0] ldr_addr = '0, ldr_wdata = '0;
  logic [31:0] ldr_rdata;
  logic        ldr_ready;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_ARB_LDR_LOCK_EN
  logic        ldr_lock = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int enCount = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .core_rd    (core_rd),
    .core_wr    (core_wr),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_rdata (core_rdata),
    .core_ready (core_ready),
    .ldr_req    (ldr_req),
    .ldr_we     (ldr_we),
    .ldr_addr   (ldr_addr),
    .ldr_wdata  (ldr_wdata),
    .ldr_rdata  (ldr_rdata),
    .ldr_ready  (ldr_ready),
`ifdef MEM_ARB_LDR_LOCK_EN
    .ldr_lock   (ldr_lock),
`endif
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  function automatic logic [31:0] memFn(input logic [31:0] a);
    if (a == 32'h40) return 32'hDEADBEEF;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory only presents real data in the last strobe cycle of an access.
  always @(posedge clk) enCount <= mem_en ? enCount + 1 : 0;
  assign mem_rdata = (mem_en && enCount == LAT - 1) ? memFn(mem_addr) : 32'hBAD0BAD0;

  typedef struct {
    logic rst, cRd, cWr; logic [31:0] cAddr, cWd;
    logic lReq, lWe;     logic [31:0] lAddr, lWd;
    logic en, we;        logic [31:0] addr, wd;
    logic cRdy, lRdy;    logic [31:0] cRdata, lRdata;
  } vec_t;

  vec_t vecs[37];

  function automatic vec_t mk(input logic rst, cRd, cWr, input logic [31:0] cAddr, cWd,
                              input logic lReq, lWe, input logic [31:0] lAddr, lWd,
                              input logic en, we, input logic [31:0] addr, wd,
                              input logic cRdy, lRdy, input logic [31:0] cRdata, lRdata);
    vec_t v;
    v.rst = rst; v.cRd = cRd; v.cWr = cWr; v.cAddr = cAddr; v.cWd = cWd;
    v.lReq = lReq; v.lWe = lWe; v.lAddr = lAddr; v.lWd = lWd;
    v.en = en; v.we = we; v.addr = addr; v.wd = wd;
    v.cRdy = cRdy; v.lRdy = lRdy; v.cRdata = cRdata; v.lRdata = lRdata;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset = v.rst; core_rd = v.cRd; core_wr = v.cWr; core_addr = v.cAddr; core_wdata = v.cWd;
    ldr_req = v.lReq; ldr_we = v.lWe; ldr_addr = v.lAddr; ldr_wdata = v.lWd;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic en, we, input logic [31:0] addr, wd,
                          input logic cRdy, lRdy, input logic [31:0] cR, lR);
    checkOutput({tag, ".mem_en"},     {31'b0, mem_en},     {31'b0, en});
    checkOutput({tag, ".mem_we"},     {31'b0, mem_we},     {31'b0, we});
    checkOutput({tag, ".mem_addr"},   mem_addr,            addr);
    checkOutput({tag, ".mem_wdata"},  mem_wdata,           wd);
    checkOutput({tag, ".core_ready"}, {31'b0, core_ready}, {31'b0, cRdy});
    checkOutput({tag, ".ldr_ready"},  {31'b0, ldr_ready},  {31'b0, lRdy});
    checkOutput({tag, ".core_rdata"}, core_rdata,          cR);
    checkOutput({tag, ".ldr_rdata"},  ldr_rdata,           lR);
  endtask

  task automatic randomPhase(input int n);
    int g;
    bit ownLdr, lastLdr, mWe, expEn, expCRdy, expLRdy, ce, le, pickLdr;
    logic [31:0] mAddr, mWd, mCR, mLR;
    reset = 1'b0; core_rd = 1'b0; core_wr = 1'b0; ldr_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    g = -100; ownLdr = 1'b0; lastLdr = 1'b1; mWe = 1'b0;
    mAddr = '0; mWd = '0; mCR = '0; mLR = '0;
    for (int c = 0; c < n; c++) begin
      expEn   = (c > g) && (c <= g + LAT);
      expCRdy = (c == g + LAT + 1) && !ownLdr;
      expLRdy = (c == g + LAT + 1) && ownLdr;
      if (c == g + LAT + 1 && !mWe) begin
        if (ownLdr) mLR = memFn(mAddr);
        else        mCR = memFn(mAddr);
      end
      checkAll($sformatf("rnd%0d", c), expEn, expEn && mWe, mAddr, mWd, expCRdy, expLRdy, mCR, mLR);
      core_rd    = ($urandom_range(0, 3) != 0);
      core_wr    = ($urandom_range(0, 3) == 0);
      core_addr  = $urandom & 32'h0000_FFFC;
      core_wdata = $urandom;
      ldr_req    = ($urandom_range(0, 2) != 0);
      ldr_we     = $urandom_range(0, 1) == 1;
      ldr_addr   = $urandom & 32'h0000_FFFC;
      ldr_wdata  = $urandom;
      if (c >= g + LAT + 1) begin
        ce = (core_rd || core_wr) && !expCRdy;
        le = ldr_req && !expLRdy;
        if (ce || le) begin
          pickLdr = (ce && le) ? !lastLdr : le;
          g = c; ownLdr = pickLdr; lastLdr = pickLdr;
          mAddr = pickLdr ? ldr_addr  : core_addr;
          mWd   = pickLdr ? ldr_wdata : core_wdata;
          mWe   = pickLdr ? ldr_we    : core_wr;
        end
      end
      @(negedge clk);
    end
  endtask

  localparam logic [31:0] A40 = 32'h40, A100 = 32'h100, A80 = 32'h80, A8 = 32'h8;
  localparam logic [31:0] DB = 32'hDEADBEEF, W1 = 32'h12345678, W2 = 32'h11112222;
  localparam logic [31:0] FF = 32'h0000FFFF, L80 = 32'h0080FF7F, A5 = 32'hA5A5A5A5;

  initial begin
    // Row i: inputs held during cycle i, expected outputs seen in cycle i+1.
    vecs[0]  = mk(0,1,0,A40,0, 1,1,A100,W1, 0,0,0,0,    0,0,0,0);
    vecs[1]  = mk(0,1,0,A40,0, 1,1,A100,W1, 0,0,0,0,    0,0,0,0);
    vecs[2]  = mk(0,1,0,A40,0, 1,1,A100,W1, 0,0,0,0,    0,0,0,0);
    vecs[3]  = mk(1,1,0,A40,0, 1,1,A100,W1, 1,0,A40,0,  0,0,0,0);
    vecs[4]  = mk(1,1,0,A40,0, 1,1,A100,W1, 1,0,A40,0,  0,0,0,0);
    vecs[5]  = mk(1,1,0,A40,0, 1,1,A100,W1, 0,0,A40,0,  1,0,DB,0);
    vecs[6]  = mk(1,0,0,A40,0, 1,1,A100,W1, 1,1,A100,W1, 0,0,DB,0);
    vecs[7]  = mk(1,0,0,A40,0, 1,1,A100,W1, 1,1,A100,W1, 0,0,DB,0);
    vecs[8]  = mk(1,0,0,A40,0, 1,1,A100,W1, 0,0,A100,W1, 0,1,DB,0);
    vecs[9]  = mk(1,0,0,A40,0, 0,1,A100,W1, 0,0,A100,W1, 0,0,DB,0);
    vecs[10] = mk(1,1,0,0,0,   1,1,A100,W1, 1,0,0,0,    0,0,DB,0);
    vecs[11] = mk(1,1,0,0,0,   1,1,A100,W1, 1,0,0,0,    0,0,DB,0);
    vecs[12] = mk(1,1,0,0,0,   1,1,A100,W1, 0,0,0,0,    1,0,FF,0);
    vecs[13] = mk(1,1,0,0,0,   1,1,A100,W1, 1,1,A100,W1, 0,0,FF,0);
    vecs[14] = mk(1,1,0,0,0,   1,1,A100,W1, 1,1,A100,W1, 0,0,FF,0);
    vecs[15] = mk(1,1,0,0,0,   1,1,A100,W1, 0,0,A100,W1, 0,1,FF,0);
    vecs[16] = mk(1,1,0,0,0,   1,1,A100,W1, 1,0,0,0,    0,0,FF,0);
    vecs[17] = mk(1,1,0,0,0,   1,1,A100,W1, 1,0,0,0,    0,0,FF,0);
    vecs[18] = mk(1,0,0,0,0,   0,1,A100,W1, 0,0,0,0,    1,0,FF,0);
    vecs[19] = mk(1,0,0,0,0,   0,1,A100,W1, 0,0,0,0,    0,0,FF,0);
    vecs[20] = mk(1,1,1,A8,A5, 1,0,A80,W2,  1,0,A80,W2, 0,0,FF,0);
    vecs[21] = mk(1,1,1,A8,A5, 1,0,A80,W2,  1,0,A80,W2, 0,0,FF,0);
    vecs[22] = mk(1,1,1,A8,A5, 1,0,A80,W2,  0,0,A80,W2, 0,1,FF,L80);
    vecs[23] = mk(1,1,1,A8,A5, 0,0,A80,W2,  1,1,A8,A5,  0,0,FF,L80);
    vecs[24] = mk(1,1,1,A8,A5, 0,0,A80,W2,  1,1,A8,A5,  0,0,FF,L80);
    vecs[25] = mk(1,1,1,A8,A5, 0,0,A80,W2,  0,0,A8,A5,  1,0,FF,L80);
    vecs[26] = mk(1,1,1,A8,A5, 0,0,A80,W2,  0,0,A8,A5,  0,0,FF,L80);
    vecs[27] = mk(1,1,1,A8,A5, 0,0,A80,W2,  1,1,A8,A5,  0,0,FF,L80);
    vecs[28] = mk(1,0,0,A8,A5, 0,0,A80,W2,  1,1,A8,A5,  0,0,FF,L80);
    vecs[29] = mk(1,0,0,A8,A5, 0,0,A80,W2,  0,0,A8,A5,  1,0,FF,L80);
    vecs[30] = mk(1,0,0,A8,A5, 0,0,A80,W2,  0,0,A8,A5,  0,0,FF,L80);
    vecs[31] = mk(1,0,0,A8,A5, 1,0,A80,W2,  1,0,A80,W2, 0,0,FF,L80);
    vecs[32] = mk(0,0,0,A8,A5, 1,0,A80,W2,  0,0,0,0,    0,0,0,0);
    vecs[33] = mk(1,1,0,A40,0, 0,0,A80,W2,  1,0,A40,0,  0,0,0,0);
    vecs[34] = mk(1,1,0,A40,0, 0,0,A80,W2,  1,0,A40,0,  0,0,0,0);
    vecs[35] = mk(1,1,0,A40,0, 0,0,A80,W2,  0,0,A40,0,  1,0,DB,0);
    vecs[36] = mk(1,0,0,A40,0, 0,0,A80,W2,  0,0,A40,0,  0,0,DB,0);

    @(negedge clk);
    for (int i = 0; i < 37; i++) begin
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkAll($sformatf("row%0d", i), vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].wd,
               vecs[i].cRdy, vecs[i].lRdy, vecs[i].cRdata, vecs[i].lRdata);
    end

    $display("[TB] directed table done, starting random traffic");
    randomPhase(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
